construct_data: RTL and testbench
=================================

// Module: construct_data
// PURPOSE
//  Write-side counterpart of the pixel unpacker: gathers OSIZE-bit pixels into ISIZE-bit bus words for the
//  VDMA write path. Pixels are packed MSB-first and may straddle word boundaries when ISIZE%OSIZE!=0.
//  It sits between the video input stream and the AXI write data FIFO. Partial words are flushed zero-padded
//  with a byte mask.
// PARAMETERS
//  ISIZE  256  output bus word width; multiple of 8, ISIZE >= OSIZE
//  OSIZE  24   input pixel width; multiple of 8
// PORTS
//  clock   in   1          single clock domain, rising edge
//  rst_n   in   1          reset, asynchronous assert, active-low
//  ialign  in   1          sync clear: discard partial word, restart packing at the MSB
//  iflush  in   1          pulse: emit the partial word, zero-padded, with olast=1
//  ivalid  in   1          idata valid
//  iready  out  1          pixel accepted when ivalid&&iready
//  idata   in   OSIZE      pixel
//  ovalid  out  1          odata/omask/olast valid
//  ordy    in   1          downstream accepts word when ovalid&&ordy
//  odata   out  ISIZE      packed word; first pixel in odata[ISIZE-1-:OSIZE]
//  omask   out  ISIZE/8    byte enables; bit i covers odata[8i+7:8i]
//  olast   out  1          word closes a flush
// BEHAVIOUR
//  - Reset (async, rst_n=0): acc=0, cnt=0, state=S_RUN, ovalid=0, odata=0, omask=0, olast=0.
//    iready is combinational and reads 1 after reset release.
//  - Accumulator acc[ISIZE+OSIZE-1:0] with bit count cnt (0..ISIZE+OSIZE-1). An accepted pixel is written
//    to acc[ISIZE+OSIZE-1-cnt -: OSIZE], and cnt += OSIZE.
//  - Word emit: if post-accept cnt >= ISIZE, load out_reg with acc top ISIZE bits and set omask all ones,
//    olast=0. Then shift acc left by ISIZE and apply cnt -= ISIZE. This happens in the accept cycle, so
//    ovalid rises 1 clock after the accept.
//  - Output is a single register slot. It is held stable while ovalid&&!ordy.
//  - iready = (state==S_RUN) && (!ovalid || ordy). One accept never produces more than one word, so this
//    rule cannot overflow the slot.
//  - Flush (state S_RUN):
//    - iflush with cnt==0 (after any same-cycle accept): no word is emitted and the flush is dropped.
//    - Otherwise, if the slot is free, emit acc top ISIZE bits with bits below cnt zeroed.
//      omask = ones in the top ceil(cnt/8) bytes, olast=1; then acc=0, cnt=0.
//    - If the slot is busy, or the same-cycle accept produced a full word, go to S_FLUSH.
//  - S_FLUSH: iready=0. When the slot frees, emit the padded flush word as above and return to S_RUN.
//  - Priority: ialign > iflush > data. ialign clears acc, cnt and S_FLUSH to S_RUN, and drops a
//    same-cycle pixel.
//  - ialign does not touch a word already in the output slot.
//  - Reset mid-operation: all state is lost immediately and any pending word is discarded.
//  - cnt arithmetic uses $clog2(ISIZE+OSIZE)+1 bits, so there is no wrap.
// STRUCTURE
//  - Shared package data_map_pkg: clog2-based width constant CNT_W, function byte_mask(cnt) (top-aligned
//    ceil(cnt/8) ones), state enum {S_RUN,S_FLUSH}.
//  - Natural sub-module: pack_mask_gen (cnt -> omask). The accumulator/FSM stays in construct_data.
// TESTING (ISIZE=256, OSIZE=24, ordy=1 unless stated)
//  1. 32 pixels p[k]=24'h010000*k+k, no stalls -> 3 words.
//     - word0[255:232]=p0; word0[15:0]=p10[23:8]; word1[255:248]=p10[7:0]; word2[23:0]=p31.
//     - omask=32'hFFFFFFFF on all words; olast=0.
//  2. Same stream, ordy low 5 cycles at word0 -> odata stable, iready=0 while stalled, no pixel lost or
//     duplicated.
//  3. 5 pixels then iflush -> one word, top 120 bits = p0..p4, rest 0, omask=32'hFFFE0000, olast=1.
//  4. 10 pixels, then p10 with iflush same cycle -> full word (olast=0, omask all ones), then 1 cycle later
//     a flush word with [255:248]=p10[7:0], omask=32'h80000000, olast=1.
//  5. 7 pixels, ialign, 11 pixels -> first word starts with the post-align pixel; the 7 stale pixels never
//     appear.
//  6. rst_n low mid-word (async, between edges) -> ovalid/omask/olast drop to 0 immediately; after release
//     the next word packs from bit 255.

Source files
------------

// File: rtl/data_map_pkg.sv
// Shared types and helpers for the pixel-to-word packer.
// Sized for the default 256-bit bus / 24-bit pixel configuration.
package data_map_pkg;

  localparam int DEF_ISIZE = 256;
  localparam int DEF_OSIZE = 24;
  localparam int CNT_W     = $clog2(DEF_ISIZE + DEF_OSIZE) + 1;
  localparam int MASK_W    = DEF_ISIZE / 8;

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  // Top-aligned byte enables covering the first ceil(cnt/8) bytes of a word.
  function automatic logic [MASK_W-1:0] byte_mask(input logic [CNT_W-1:0] cnt);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      m[MASK_W-1-i] = (CNT_W'(8 * i) < cnt);
    end
    return m;
  endfunction

endpackage

// File: rtl/pack_mask_gen.sv
// Bit count -> top-aligned byte mask for a partial flush word.
// Purely combinational; no flow control.
module pack_mask_gen
  import data_map_pkg::*;
#(
  parameter int ISIZE = 256,
  parameter int CW    = CNT_W
) (
  input  logic [CW-1:0]      i_cnt,
  output logic [ISIZE/8-1:0] o_mask
);

  localparam int NB = ISIZE / 8;

  if (NB == MASK_W && CW == CNT_W) begin : g_pkg
    assign o_mask = byte_mask(i_cnt);
  end else begin : g_loop
    always_comb begin
      o_mask = '0;
      for (int i = 0; i < NB; i++) begin
        o_mask[NB-1-i] = (CW'(8 * i) < i_cnt);
      end
    end
  end

endmodule

// File: rtl/construct_data.sv
// Packs OSIZE-bit pixels MSB-first into ISIZE-bit words; a word appears 1 clock after the completing accept.
// Single-slot output held while ovalid&&!ordy; iready drops while the slot is blocked or a flush is pending.
module construct_data
  import data_map_pkg::*;
#(
  parameter int ISIZE = 256,
  parameter int OSIZE = 24
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               ialign,
  input  logic               iflush,
  input  logic               ivalid,
  output logic               iready,
  input  logic [OSIZE-1:0]   idata,
  output logic               ovalid,
  input  logic               ordy,
  output logic [ISIZE-1:0]   odata,
  output logic [ISIZE/8-1:0] omask,
  output logic               olast
);

  localparam int AW = ISIZE + OSIZE;
  localparam int CW = $clog2(ISIZE + OSIZE) + 1;
  localparam int NB = ISIZE / 8;
  localparam logic [CW-1:0] C_ISIZE = CW'(ISIZE);
  localparam logic [CW-1:0] C_OSIZE = CW'(OSIZE);

  state_t           r_state;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_ovalid;
  logic             r_olast;
  logic [ISIZE-1:0] r_odata;
  logic [NB-1:0]    r_omask;

  logic             w_slot_free;
  logic             w_accept;
  logic             w_full;
  logic [AW-1:0]    w_acc_ins;
  logic [AW-1:0]    w_acc_post;
  logic [CW-1:0]    w_cnt_ins;
  logic [CW-1:0]    w_cnt_post;
  logic [CW-1:0]    w_fcnt;
  logic [ISIZE-1:0] w_ftop;
  logic [ISIZE-1:0] w_fdata;
  logic [NB-1:0]    w_fmask;

  assign w_slot_free = !r_ovalid || ordy;
  assign iready      = (r_state == S_RUN) && w_slot_free;
  assign w_accept    = ivalid && iready;

  // Insert at the current fill point, then peel off a full word if one completed.
  always_comb begin
    w_acc_ins = r_acc;
    w_cnt_ins = r_cnt;
    if (w_accept) begin
      w_acc_ins = r_acc | ({idata, {ISIZE{1'b0}}} >> r_cnt);
      w_cnt_ins = r_cnt + C_OSIZE;
    end
    w_full     = w_accept && (w_cnt_ins >= C_ISIZE);
    w_acc_post = w_full ? (w_acc_ins << ISIZE) : w_acc_ins;
    w_cnt_post = w_full ? (w_cnt_ins - C_ISIZE) : w_cnt_ins;
  end

  assign w_fcnt  = (r_state == S_FLUSH) ? r_cnt : w_cnt_post;
  assign w_ftop  = (r_state == S_FLUSH) ? r_acc[AW-1 -: ISIZE] : w_acc_post[AW-1 -: ISIZE];
  assign w_fdata = w_ftop & ~({ISIZE{1'b1}} >> w_fcnt);

  pack_mask_gen #(
    .ISIZE (ISIZE),
    .CW    (CW)
  ) u_mask (
    .i_cnt  (w_fcnt),
    .o_mask (w_fmask)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RUN;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ovalid <= 1'b0;
      r_odata  <= '0;
      r_omask  <= '0;
      r_olast  <= 1'b0;
    end else begin
      if (r_ovalid && ordy) r_ovalid <= 1'b0;
      if (ialign) begin
        // The output slot is left alone; only the packing state restarts.
        r_acc   <= '0;
        r_cnt   <= '0;
        r_state <= S_RUN;
      end else if (r_state == S_FLUSH) begin
        if (w_slot_free) begin
          r_ovalid <= 1'b1;
          r_odata  <= w_fdata;
          r_omask  <= w_fmask;
          r_olast  <= 1'b1;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_state  <= S_RUN;
        end
      end else begin
        r_acc <= w_acc_post;
        r_cnt <= w_cnt_post;
        if (w_full) begin
          r_ovalid <= 1'b1;
          r_odata  <= w_acc_ins[AW-1 -: ISIZE];
          r_omask  <= '1;
          r_olast  <= 1'b0;
        end
        // A flush with nothing left over after the accept is simply dropped.
        if (iflush && (w_cnt_post != '0)) begin
          if (!w_full && w_slot_free) begin
            r_ovalid <= 1'b1;
            r_odata  <= w_fdata;
            r_omask  <= w_fmask;
            r_olast  <= 1'b1;
            r_acc    <= '0;
            r_cnt    <= '0;
          end else begin
            r_state <= S_FLUSH;
          end
        end
      end
    end
  end

  assign ovalid = r_ovalid;
  assign odata  = r_odata;
  assign omask  = r_omask;
  assign olast  = r_olast;

endmodule

// File: tb/tb_construct_data.sv
// Directed bench for construct_data at ISIZE=256, OSIZE=24.
module tb_construct_data;

  logic         clock = 1'b0;
  logic         rst_n;
  logic         ialign;
  logic         iflush;
  logic         ivalid;
  logic         iready;
  logic [23:0]  idata;
  logic         ovalid;
  logic         ordy;
  logic [255:0] odata;
  logic [31:0]  omask;
  logic         olast;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [255:0] q_dat[$];
  logic [31:0]  q_msk[$];
  logic         q_lst[$];
  int           q_cyc[$];

  construct_data #(.ISIZE(256), .OSIZE(24)) dut (
    .clock  (clock),
    .rst_n  (rst_n),
    .ialign (ialign),
    .iflush (iflush),
    .ivalid (ivalid),
    .iready (iready),
    .idata  (idata),
    .ovalid (ovalid),
    .ordy   (ordy),
    .odata  (odata),
    .omask  (omask),
    .olast  (olast)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Log every word that completes a handshake at the coming rising edge.
  always @(negedge clock) begin
    if (rst_n && ovalid && ordy) begin
      q_dat.push_back(odata);
      q_msk.push_back(omask);
      q_lst.push_back(olast);
      q_cyc.push_back(cyc);
    end
  end

  function automatic logic [23:0] pix(input int k);
    return 24'((32'h010000 * k) + k);
  endfunction

  // Reference bit stream: pixels base..base+n-1 concatenated MSB-first.
  function automatic logic [767:0] stream(input int base, input int n);
    logic [767:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s[767 - 24 * i -: 24] = pix(base + i);
    return s;
  endfunction

  task automatic do_reset();
    rst_n  = 1'b0;
    ialign = 1'b0;
    iflush = 1'b0;
    ivalid = 1'b0;
    idata  = '0;
    ordy   = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    q_dat.delete(); q_msk.delete(); q_lst.delete(); q_cyc.delete();
    rst_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic send_pixels(input int n, input int base, input bit flush_last);
    bit got;
    int tmo;
    for (int k = 0; k < n; k++) begin
      ivalid = 1'b1;
      idata  = pix(base + k);
      iflush = flush_last && (k == n - 1);
      tmo    = 0;
      got    = 1'b0;
      while (!got && tmo < 200) begin
        @(negedge clock);
        got = iready;
        @(posedge clock);
        #1;
        tmo++;
      end
      if (!got) begin
        n_total++;
        $display("FAIL send_timeout: pixel %0d not accepted within %0d cycles", base + k, tmo);
      end
    end
    ivalid = 1'b0;
    iflush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ialign = 1'b0; iflush = 1'b0; ivalid = 1'b0; idata = '0; ordy = 1'b1;
    repeat (2) @(negedge clock);
    n_total++;
    if (ovalid !== 1'b0) $display("FAIL reset_ovalid: got %b expected 0", ovalid); else n_pass++;
    n_total++;
    if (odata !== 256'd0) $display("FAIL reset_odata: got %h expected 0", odata); else n_pass++;
    n_total++;
    if (omask !== 32'd0) $display("FAIL reset_omask: got %h expected 0", omask); else n_pass++;
    n_total++;
    if (olast !== 1'b0) $display("FAIL reset_olast: got %b expected 0", olast); else n_pass++;
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(negedge clock);
    n_total++;
    if (iready !== 1'b1) $display("FAIL reset_iready: got %b expected 1", iready); else n_pass++;
    @(posedge clock); #1;
  endtask

  task automatic test_stream();
    logic [767:0] s;
    do_reset();
    send_pixels(32, 0, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    s = stream(0, 32);
    n_total++;
    if (q_dat.size() !== 3) $display("FAIL stream_count: got %0d words expected 3", q_dat.size()); else n_pass++;
    if (q_dat.size() >= 3) begin
      n_total++;
      if (q_dat[0][255:232] !== 24'h000000) $display("FAIL stream_w0_p0: got %h expected 000000", q_dat[0][255:232]); else n_pass++;
      n_total++;
      if (q_dat[0][15:0] !== 16'h0A00) $display("FAIL stream_w0_tail: got %h expected 0a00", q_dat[0][15:0]); else n_pass++;
      n_total++;
      if (q_dat[1][255:248] !== 8'h0A) $display("FAIL stream_w1_head: got %h expected 0a", q_dat[1][255:248]); else n_pass++;
      n_total++;
      if (q_dat[2][23:0] !== 24'h1F001F) $display("FAIL stream_w2_p31: got %h expected 1f001f", q_dat[2][23:0]); else n_pass++;
      for (int w = 0; w < 3; w++) begin
        n_total++;
        if (q_dat[w] !== s[767 - 256 * w -: 256])
          $display("FAIL stream_word%0d: got %h expected %h", w, q_dat[w], s[767 - 256 * w -: 256]);
        else n_pass++;
        n_total++;
        if (q_msk[w] !== 32'hFFFFFFFF || q_lst[w] !== 1'b0)
          $display("FAIL stream_mask%0d: got mask %h last %b expected ffffffff/0", w, q_msk[w], q_lst[w]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [767:0] s;
    logic [255:0] held;
    do_reset();
    s    = stream(0, 32);
    ordy = 1'b0;
    fork
      send_pixels(32, 0, 1'b0);
      begin
        int t;
        t = 0;
        @(negedge clock);
        while (!ovalid && t < 200) begin
          @(negedge clock);
          t++;
        end
        held = odata;
        n_total++;
        if (held !== s[767 -: 256]) $display("FAIL stall_word0: got %h expected %h", held, s[767 -: 256]); else n_pass++;
        for (int c = 0; c < 5; c++) begin
          @(negedge clock);
          n_total++;
          if (odata !== held || ovalid !== 1'b1)
            $display("FAIL stall_hold%0d: got %h valid %b expected %h valid 1", c, odata, ovalid, held);
          else n_pass++;
          n_total++;
          if (iready !== 1'b0) $display("FAIL stall_iready%0d: got %b expected 0", c, iready); else n_pass++;
        end
        @(posedge clock); #1;
        ordy = 1'b1;
      end
    join
    repeat (4) @(posedge clock);
    #1;
    n_total++;
    if (q_dat.size() !== 3) $display("FAIL stall_count: got %0d words expected 3", q_dat.size()); else n_pass++;
    if (q_dat.size() >= 3) begin
      for (int w = 0; w < 3; w++) begin
        n_total++;
        if (q_dat[w] !== s[767 - 256 * w -: 256])
          $display("FAIL stall_word%0d: got %h expected %h", w, q_dat[w], s[767 - 256 * w -: 256]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_flush_partial();
    logic [255:0] exp;
    do_reset();
    send_pixels(5, 0, 1'b0);
    iflush = 1'b1;
    @(posedge clock); #1;
    iflush = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    exp = {24'h000000, 24'h010001, 24'h020002, 24'h030003, 24'h040004, 136'd0};
    n_total++;
    if (q_dat.size() !== 1) $display("FAIL flush_count: got %0d words expected 1", q_dat.size()); else n_pass++;
    if (q_dat.size() >= 1) begin
      n_total++;
      if (q_dat[0] !== exp) $display("FAIL flush_data: got %h expected %h", q_dat[0], exp); else n_pass++;
      n_total++;
      if (q_msk[0] !== 32'hFFFE0000) $display("FAIL flush_mask: got %h expected fffe0000", q_msk[0]); else n_pass++;
      n_total++;
      if (q_lst[0] !== 1'b1) $display("FAIL flush_last: got %b expected 1", q_lst[0]); else n_pass++;
    end
  endtask

  task automatic test_flush_straddle();
    logic [767:0] s;
    do_reset();
    send_pixels(10, 0, 1'b0);
    send_pixels(1, 10, 1'b1);
    repeat (4) @(posedge clock);
    #1;
    s = stream(0, 11);
    n_total++;
    if (q_dat.size() !== 2) $display("FAIL straddle_count: got %0d words expected 2", q_dat.size()); else n_pass++;
    if (q_dat.size() >= 2) begin
      n_total++;
      if (q_dat[0] !== s[767 -: 256] || q_msk[0] !== 32'hFFFFFFFF || q_lst[0] !== 1'b0)
        $display("FAIL straddle_full: got %h/%h/%b expected %h/ffffffff/0", q_dat[0], q_msk[0], q_lst[0], s[767 -: 256]);
      else n_pass++;
      n_total++;
      if (q_dat[1] !== {8'h0A, 248'd0}) $display("FAIL straddle_data: got %h expected 0a followed by zeros", q_dat[1]); else n_pass++;
      n_total++;
      if (q_msk[1] !== 32'h80000000 || q_lst[1] !== 1'b1)
        $display("FAIL straddle_mask: got %h/%b expected 80000000/1", q_msk[1], q_lst[1]);
      else n_pass++;
      n_total++;
      if (q_cyc[1] - q_cyc[0] !== 1) $display("FAIL straddle_gap: got %0d cycles expected 1", q_cyc[1] - q_cyc[0]); else n_pass++;
    end
  endtask

  task automatic test_align();
    logic [767:0] s;
    do_reset();
    send_pixels(7, 0, 1'b0);
    ialign = 1'b1;
    @(posedge clock); #1;
    ialign = 1'b0;
    send_pixels(11, 100, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    s = stream(100, 11);
    n_total++;
    if (q_dat.size() !== 1) $display("FAIL align_count: got %0d words expected 1", q_dat.size()); else n_pass++;
    if (q_dat.size() >= 1) begin
      n_total++;
      if (q_dat[0][255:232] !== 24'h640064) $display("FAIL align_head: got %h expected 640064", q_dat[0][255:232]); else n_pass++;
      n_total++;
      if (q_dat[0] !== s[767 -: 256]) $display("FAIL align_word: got %h expected %h", q_dat[0], s[767 -: 256]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [767:0] s;
    do_reset();
    ordy = 1'b0;
    send_pixels(11, 0, 1'b0);
    @(negedge clock);
    n_total++;
    if (ovalid !== 1'b1) $display("FAIL midrst_pending: got %b expected 1", ovalid); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (ovalid !== 1'b0 || omask !== 32'd0 || olast !== 1'b0)
      $display("FAIL midrst_async: got valid %b mask %h last %b expected 0/0/0", ovalid, omask, olast);
    else n_pass++;
    n_total++;
    if (odata !== 256'd0) $display("FAIL midrst_odata: got %h expected 0", odata); else n_pass++;
    @(posedge clock); #1;
    rst_n = 1'b1;
    ordy  = 1'b1;
    send_pixels(11, 200, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    s = stream(200, 11);
    n_total++;
    if (q_dat.size() !== 1) $display("FAIL midrst_count: got %0d words expected 1", q_dat.size()); else n_pass++;
    if (q_dat.size() >= 1) begin
      n_total++;
      if (q_dat[0] !== s[767 -: 256]) $display("FAIL midrst_word: got %h expected %h", q_dat[0], s[767 -: 256]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back_stall();
    test_flush_partial();
    test_flush_straddle();
    test_align();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
